btn_pr_in: RTL and testbench

Debounced two-channel push-button input block for the PL partial-reconfiguration lab. It is the input counterpart to the LED driver modules: those drive a 2-bit `led` bus to the board, and this block takes the 2-bit raw button bus from the board. It synchronises, debounces and edge-detects each button, and delivers clean levels plus single-cycle press, release and long-press events to the reconfigurable LED logic. It sits in the static region, so its outputs remain valid across reconfiguration of LED partitions.

---
 rtl/btn_pr_in.sv | 124 ++++++++++++
 tb/tb_btn_pr_in.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_pr_in.sv
// btn_pr_in: two-channel push-button input block.
// Each raw button is synchronised, debounced by a small FSM, and turned into a
// clean level plus single-cycle press, release and long-press events.
module btn_pr_in #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] btn,
  output logic [1:0] btn_level,
  output logic [1:0] btn_press,
  output logic [1:0] btn_release,
  output logic [1:0] btn_long
);

  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [1:0] s1;
  logic [1:0] s2;

  // Two-flop synchroniser for the asynchronous button inputs; only s2 is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_ch
    state_t              state;
    logic [DEB_W-1:0]    cnt;
    logic [HOLD_W-1:0]   hold;
    logic                level_q;
    logic                press_q;
    logic                release_q;
    logic                long_q;

    // Per-channel debounce FSM with registered level and event pulses.
    // The hold counter is kept through RELEASE_WAIT so a release bounce
    // neither re-arms the long-press event nor produces a second press.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= RELEASED;
        cnt       <= '0;
        hold      <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        case (state)
          RELEASED: begin
            if (s2[i]) begin
              state <= PRESS_WAIT;
              cnt   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!s2[i]) begin
              state <= RELEASED;
            end else if (cnt == DEB_LAST) begin
              state   <= HELD;
              level_q <= 1'b1;
              press_q <= 1'b1;
              hold    <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HELD: begin
            if (!s2[i]) begin
              state <= RELEASE_WAIT;
              cnt   <= '0;
            end else if (hold < HOLD_MAX) begin
              hold <= hold + 1'b1;
              if (hold == HOLD_MAX - HOLD_ONE) begin
                long_q <= 1'b1;
              end
            end
          end
          RELEASE_WAIT: begin
            if (s2[i]) begin
              state <= HELD;
            end else if (cnt == DEB_LAST) begin
              state     <= RELEASED;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= RELEASED;
          end
        endcase
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_long[i]    = long_q;
  end

endmodule

// File: tb/tb_btn_pr_in.sv
// tb_btn_pr_in: table-driven checks of btn_pr_in at default parameters,
// plus hand-written sequences for latency, same-cycle and reset corners.
module tb_btn_pr_in;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] btn = 2'b00;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] btn_long;

  always #5 clk = ~clk;

  btn_pr_in #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  typedef struct {
    logic [1:0] b;
    int         n;
    logic [1:0] lvl;
    int         p0, p1, r0, r1, l0, l1;
  } vec_t;

  vec_t tbl[$];

  int n_chk  = 0;
  int n_pass = 0;
  int np[2];
  int nr[2];
  int nl[2];
  int nlv[2];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 2; c++) begin
      np[c] = 0; nr[c] = 0; nl[c] = 0; nlv[c] = 0;
    end
  endtask

  // One clock: advance through a rising edge, sample on the falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      np[c]  += int'(btn_press[c]);
      nr[c]  += int'(btn_release[c]);
      nl[c]  += int'(btn_long[c]);
      nlv[c] += int'(btn_level[c]);
    end
  endtask

  // Count rising edges until the chosen condition holds; -1 on timeout.
  // kind: 0 level high, 1 press, 2 long, 3 level low
  task automatic wait_sig(input int kind, input int ch, input int max, output int edges);
    logic v;
    v = 1'b0;
    edges = 0;
    while (!v && edges < max) begin
      cycle();
      edges++;
      case (kind)
        0: v = btn_level[ch];
        1: v = btn_press[ch];
        2: v = btn_long[ch];
        3: v = !btn_level[ch];
        default: v = 1'b0;
      endcase
    end
    if (!v) edges = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e;

    // 1-cycle pulse, then idle
    tbl.push_back('{2'b01, 1,  2'b00, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{2'b00, 10, 2'b00, 0, 0, 0, 0, 0, 0});
    // channel 1 bounce 1,0,1,0 two cycles each, then settles low
    tbl.push_back('{2'b10, 2,  2'b00, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{2'b00, 2,  2'b00, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{2'b10, 2,  2'b00, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{2'b00, 2,  2'b00, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{2'b00, 10, 2'b00, 0, 0, 0, 0, 0, 0});
    // pulse of DEBOUNCE_CYCLES is rejected
    tbl.push_back('{2'b01, 4,  2'b00, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{2'b00, 10, 2'b00, 0, 0, 0, 0, 0, 0});
    // pulse of DEBOUNCE_CYCLES+1 is accepted, then released
    tbl.push_back('{2'b01, 5,  2'b00, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{2'b00, 12, 2'b00, 1, 0, 1, 0, 0, 0});
    // release bounce while held: no release, no second press, one long
    tbl.push_back('{2'b01, 12, 2'b01, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{2'b00, 3,  2'b01, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{2'b01, 30, 2'b01, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{2'b00, 10, 2'b00, 0, 0, 1, 0, 0, 0});
    // short hold: press and release, no long
    tbl.push_back('{2'b01, 8,  2'b01, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{2'b00, 10, 2'b00, 0, 0, 1, 0, 0, 0});

    // Reset state, with buttons pressed during reset
    btn = 2'b11;
    clear_counts();
    repeat (3) cycle();
    check("reset_level",   int'(btn_level),   0);
    check("reset_press",   int'(btn_press),   0);
    check("reset_release", int'(btn_release), 0);
    check("reset_long",    int'(btn_long),    0);
    btn = 2'b00;
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (4) cycle();
    check("idle_level", int'(btn_level), 0);

    // Clean press/release on channel 0, 40 cycles held
    btn = 2'b01;
    clear_counts();
    wait_sig(0, 0, 20, e);
    check("clean_press_latency", (e < 0) ? -1 : e - 1, 6);
    check("clean_press_pulse", int'(btn_press), 1);
    wait_sig(2, 0, 40, e);
    check("clean_long_latency", e, 16);
    repeat (18) cycle();
    btn = 2'b00;
    wait_sig(3, 0, 20, e);
    check("clean_release_latency", (e < 0) ? -1 : e - 1, 6);
    check("clean_release_pulse", int'(btn_release), 1);
    repeat (4) cycle();
    check("clean_press_count",   np[0], 1);
    check("clean_release_count", nr[0], 1);
    check("clean_long_count",    nl[0], 1);
    check("clean_ch1_events",    np[1] + nr[1] + nl[1], 0);
    check("clean_ch1_level",     nlv[1], 0);

    // Table-driven segments
    for (int i = 0; i < tbl.size(); i++) begin
      btn = tbl[i].b;
      clear_counts();
      repeat (tbl[i].n) cycle();
      check($sformatf("vec%0d.level", i), int'(btn_level), int'(tbl[i].lvl));
      check($sformatf("vec%0d.press0", i),   np[0], tbl[i].p0);
      check($sformatf("vec%0d.press1", i),   np[1], tbl[i].p1);
      check($sformatf("vec%0d.release0", i), nr[0], tbl[i].r0);
      check($sformatf("vec%0d.release1", i), nr[1], tbl[i].r1);
      check($sformatf("vec%0d.long0", i),    nl[0], tbl[i].l0);
      check($sformatf("vec%0d.long1", i),    nl[1], tbl[i].l1);
    end

    // Simultaneous channels: same-cycle press and long
    btn = 2'b11;
    clear_counts();
    wait_sig(1, 0, 20, e);
    check("sim_press_latency", (e < 0) ? -1 : e - 1, 6);
    check("sim_press_both", int'(btn_press), 3);
    wait_sig(2, 0, 40, e);
    check("sim_long_latency", e, 16);
    check("sim_long_both", int'(btn_long), 3);
    repeat (8) cycle();
    check("sim_press_count1", np[1], 1);
    check("sim_long_count1",  nl[1], 1);
    btn = 2'b00;
    repeat (12) cycle();
    check("sim_release_level", int'(btn_level), 0);

    // Reset while channel 0 is held
    btn = 2'b01;
    wait_sig(0, 0, 20, e);
    check("rst_pre_latency", (e < 0) ? -1 : e - 1, 6);
    repeat (3) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_level", int'(btn_level), 0);
    clear_counts();
    repeat (3) cycle();
    check("rst_no_release", nr[0], 0);
    check("rst_level_low",  nlv[0], 0);
    rst_n = 1'b1;
    wait_sig(1, 0, 20, e);
    check("rst_repress_latency", (e < 0) ? -1 : e - 1, 6);
    check("rst_repress_level", int'(btn_level), 1);
    btn = 2'b00;
    repeat (12) cycle();
    check("rst_final_level", int'(btn_level), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
